// File: rtl/hazard_ctrl_if.sv
// Pipeline hazard-control bundle: ID/EX/MEM/WB register tags and qualifiers in,
// stall/flush enables, forwarding selects and performance counters out.
interface hazard_ctrl_if #(
  parameter int unsigned CNT_W = 32
);
  logic [4:0]       rs1D;
  logic [4:0]       rs2D;
  logic [4:0]       rs1E;
  logic [4:0]       rs2E;
  logic [4:0]       rdE;
  logic [4:0]       rdM;
  logic [4:0]       rdW;
  logic             regwriteM;
  logic             regwriteW;
  logic             loadE;
  logic             pcsrcE;
  logic             mdstartE;

  logic             enF;
  logic             enD;
  logic             enE;
  logic             clrD;
  logic             clrE;
  logic             clrM;
  logic [1:0]       forwardAE;
  logic [1:0]       forwardBE;
  logic             mdbusy;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW,
    output regwriteM, regwriteW, loadE, pcsrcE, mdstartE,
    input  enF, enD, enE, clrD, clrE, clrM, forwardAE, forwardBE,
    input  mdbusy, stall_cnt, flush_cnt
  );

  modport slave (
    input  rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW,
    input  regwriteM, regwriteW, loadE, pcsrcE, mdstartE,
    output enF, enD, enE, clrD, clrE, clrM, forwardAE, forwardBE,
    output mdbusy, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard/pipeline-control unit for the 5-stage RV32 pipeline: forwarding,
// load-use and MUL/DIV stalls, branch flushes, saturating stall/flush counters.
module hazard_ctrl #(
  parameter int unsigned MD_LATENCY = 4,
  parameter int unsigned CNT_W      = 32
) (
  input logic           clk,
  input logic           reset,
  hazard_ctrl_if.slave  hz
);

  typedef enum logic {IDLE, BUSY} state_e;

  localparam logic [3:0] MD_LOAD = 4'(MD_LATENCY - 2);

  state_e           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic lwstall;
  logic mdstall;
  logic enF_s;
  logic clrD_s;
  logic clrE_s;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (hz.mdstartE) begin
          state_d = BUSY;
          cnt_d   = MD_LOAD;
        end
      end
      BUSY: begin
        if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
        else               state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // mdstall is gated by reset so an in-flight op releases EX the moment reset asserts
  always_comb begin
    mdstall = 1'b0;
    if (!reset) begin
      if (state_q == IDLE) mdstall = hz.mdstartE;
      else                 mdstall = (cnt_q != 4'd0);
    end

    lwstall = hz.loadE && (hz.rdE != 5'd0) &&
              ((hz.rdE == hz.rs1D) || (hz.rdE == hz.rs2D));

    enF_s  = !(lwstall || mdstall);
    clrD_s = hz.pcsrcE && !mdstall;
    clrE_s = (lwstall || hz.pcsrcE) && !mdstall;

    hz.enF    = enF_s;
    hz.enD    = enF_s;
    hz.enE    = !mdstall;
    hz.clrD   = clrD_s;
    hz.clrE   = clrE_s;
    hz.clrM   = mdstall;
    hz.mdbusy = (state_q == BUSY);

    if (hz.regwriteM && (hz.rdM != 5'd0) && (hz.rdM == hz.rs1E))      hz.forwardAE = 2'b10;
    else if (hz.regwriteW && (hz.rdW != 5'd0) && (hz.rdW == hz.rs1E)) hz.forwardAE = 2'b01;
    else                                                              hz.forwardAE = 2'b00;

    if (hz.regwriteM && (hz.rdM != 5'd0) && (hz.rdM == hz.rs2E))      hz.forwardBE = 2'b10;
    else if (hz.regwriteW && (hz.rdW != 5'd0) && (hz.rdW == hz.rs2E)) hz.forwardBE = 2'b01;
    else                                                              hz.forwardBE = 2'b00;
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (!enF_s && (stall_cnt_q != '1))               stall_cnt_d = stall_cnt_q + 1'b1;
    if ((clrD_s || clrE_s) && (flush_cnt_q != '1))   flush_cnt_d = flush_cnt_q + 1'b1;
  end

  assign hz.stall_cnt = stall_cnt_q;
  assign hz.flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: stimulus pushes hand-computed expectations into
// a queue; a negedge monitor pops and compares them against the DUT outputs.
module tb_hazard_ctrl;

  localparam int unsigned CW = 4;

  typedef struct {
    logic       reset;
    logic [4:0] rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
    logic       regwriteM, regwriteW, loadE, pcsrcE, mdstartE;
  } stim_t;

  typedef struct {
    string      name;
    logic       enF, enD, enE, clrD, clrE, clrM, mdbusy;
    logic [1:0] fA, fB;
    logic [3:0] sc, fc;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  hazard_ctrl_if #(.CNT_W(CW)) hif ();

  hazard_ctrl #(.MD_LATENCY(4), .CNT_W(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .hz    (hif.slave)
  );

  function automatic stim_t base(logic rst);
    stim_t s;
    s.reset = rst;
    s.rs1D = 5'd0; s.rs2D = 5'd0; s.rs1E = 5'd0; s.rs2E = 5'd0;
    s.rdE = 5'd0;  s.rdM = 5'd0;  s.rdW = 5'd0;
    s.regwriteM = 1'b0; s.regwriteW = 1'b0; s.loadE = 1'b0;
    s.pcsrcE = 1'b0; s.mdstartE = 1'b0;
    return s;
  endfunction

  // idle outputs: everything enabled, nothing cleared, no forwarding
  function automatic exp_t nominal(string nm, logic [3:0] sc, logic [3:0] fc);
    exp_t e;
    e.name = nm;
    e.enF = 1'b1; e.enD = 1'b1; e.enE = 1'b1;
    e.clrD = 1'b0; e.clrE = 1'b0; e.clrM = 1'b0; e.mdbusy = 1'b0;
    e.fA = 2'b00; e.fB = 2'b00; e.sc = sc; e.fc = fc;
    return e;
  endfunction

  function automatic exp_t mdhold(string nm, logic busy, logic [3:0] sc, logic [3:0] fc);
    exp_t e = nominal(nm, sc, fc);
    e.enF = 1'b0; e.enD = 1'b0; e.enE = 1'b0; e.clrM = 1'b1; e.mdbusy = busy;
    return e;
  endfunction

  task automatic step(input stim_t s, input exp_t e);
    @(posedge clk);
    #1;
    reset         = s.reset;
    hif.rs1D      = s.rs1D;      hif.rs2D      = s.rs2D;
    hif.rs1E      = s.rs1E;      hif.rs2E      = s.rs2E;
    hif.rdE       = s.rdE;       hif.rdM       = s.rdM;      hif.rdW = s.rdW;
    hif.regwriteM = s.regwriteM; hif.regwriteW = s.regwriteW;
    hif.loadE     = s.loadE;     hif.pcsrcE    = s.pcsrcE;   hif.mdstartE = s.mdstartE;
    exp_q.push_back(e);
  endtask

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, req);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk({e.name, ".enF"},    8'(hif.enF),       8'(e.enF));
        chk({e.name, ".enD"},    8'(hif.enD),       8'(e.enD));
        chk({e.name, ".enE"},    8'(hif.enE),       8'(e.enE));
        chk({e.name, ".clrD"},   8'(hif.clrD),      8'(e.clrD));
        chk({e.name, ".clrE"},   8'(hif.clrE),      8'(e.clrE));
        chk({e.name, ".clrM"},   8'(hif.clrM),      8'(e.clrM));
        chk({e.name, ".mdbusy"}, 8'(hif.mdbusy),    8'(e.mdbusy));
        chk({e.name, ".fwdA"},   8'(hif.forwardAE), 8'(e.fA));
        chk({e.name, ".fwdB"},   8'(hif.forwardBE), 8'(e.fB));
        chk({e.name, ".stall"},  8'(hif.stall_cnt), 8'(e.sc));
        chk({e.name, ".flush"},  8'(hif.flush_cnt), 8'(e.fc));
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    stim_t s;
    exp_t  e;
    reset = 1'b1;
    s = base(1'b0);
    hif.rs1D = '0; hif.rs2D = '0; hif.rs1E = '0; hif.rs2E = '0;
    hif.rdE = '0; hif.rdM = '0; hif.rdW = '0;
    hif.regwriteM = 1'b0; hif.regwriteW = 1'b0; hif.loadE = 1'b0;
    hif.pcsrcE = 1'b0; hif.mdstartE = 1'b0;

    step(base(1'b1), nominal("reset", 4'd0, 4'd0));

    // forwarding
    s = base(1'b0); s.rs1E = 5'd5; s.rdM = 5'd5; s.regwriteM = 1'b1; s.rdW = 5'd5; s.regwriteW = 1'b1;
    e = nominal("fwdA_mem", 4'd0, 4'd0); e.fA = 2'b10;
    step(s, e);
    s.rdM = 5'd0;
    e = nominal("fwdA_wb", 4'd0, 4'd0); e.fA = 2'b01;
    step(s, e);
    s.rdM = 5'd5; s.regwriteM = 1'b0;
    e = nominal("fwdA_nowm", 4'd0, 4'd0); e.fA = 2'b01;
    step(s, e);
    s = base(1'b0); s.rs2E = 5'd0; s.rdW = 5'd0; s.regwriteW = 1'b1; s.rdM = 5'd0; s.regwriteM = 1'b1;
    step(s, nominal("fwdB_x0", 4'd0, 4'd0));
    s = base(1'b0); s.rs2E = 5'd3; s.rdM = 5'd3; s.regwriteM = 1'b1; s.rdW = 5'd3; s.regwriteW = 1'b1;
    e = nominal("fwdB_mem", 4'd0, 4'd0); e.fB = 2'b10;
    step(s, e);
    s.regwriteM = 1'b0;
    e = nominal("fwdB_wb", 4'd0, 4'd0); e.fB = 2'b01;
    step(s, e);

    // load-use
    s = base(1'b0); s.loadE = 1'b1; s.rdE = 5'd7; s.rs2D = 5'd7;
    e = nominal("lwstall", 4'd0, 4'd0); e.enF = 1'b0; e.enD = 1'b0; e.clrE = 1'b1;
    step(s, e);
    s = base(1'b0); s.loadE = 1'b1; s.rdE = 5'd0;
    step(s, nominal("lw_x0", 4'd1, 4'd1));

    // branch flush
    s = base(1'b0); s.pcsrcE = 1'b1;
    e = nominal("branch", 4'd1, 4'd1); e.clrD = 1'b1; e.clrE = 1'b1;
    step(s, e);

    // load-use with simultaneous branch
    s = base(1'b0); s.loadE = 1'b1; s.rdE = 5'd7; s.rs1D = 5'd7; s.pcsrcE = 1'b1;
    e = nominal("lw_branch", 4'd1, 4'd2); e.enF = 1'b0; e.enD = 1'b0; e.clrD = 1'b1; e.clrE = 1'b1;
    step(s, e);

    // MUL/DIV, latency 4: three held cycles, branch ignored while held
    s = base(1'b0); s.mdstartE = 1'b1;
    step(s, mdhold("md_c0", 1'b0, 4'd2, 4'd3));
    step(s, mdhold("md_c1", 1'b1, 4'd3, 4'd3));
    s.pcsrcE = 1'b1;
    step(s, mdhold("md_c2_br", 1'b1, 4'd4, 4'd3));
    s.pcsrcE = 1'b0;
    e = nominal("md_c3", 4'd5, 4'd3); e.mdbusy = 1'b1;
    step(s, e);

    // back-to-back restart, then reset while BUSY with cnt=1
    step(s, mdhold("md2_c0", 1'b0, 4'd5, 4'd3));
    step(s, mdhold("md2_c1", 1'b1, 4'd6, 4'd3));
    s.reset = 1'b1;
    step(s, nominal("md_reset", 4'd0, 4'd0));
    step(base(1'b0), nominal("post_reset", 4'd0, 4'd0));

    // counter saturation at 15
    s = base(1'b0); s.loadE = 1'b1; s.rdE = 5'd7; s.rs1D = 5'd7;
    for (int i = 0; i < 20; i++) begin
      e = nominal($sformatf("sat%0d", i), 4'((i > 15) ? 15 : i), 4'((i > 15) ? 15 : i));
      e.enF = 1'b0; e.enD = 1'b0; e.clrE = 1'b1;
      step(s, e);
    end
    step(base(1'b0), nominal("sat_hold", 4'd15, 4'd15));

    for (int n = 0; n < 8 && exp_q.size() > 0; n++) @(negedge clk);
    if (exp_q.size() > 0) begin
      failures++;
      $display("FAIL drain actual=%0d expected=0", exp_q.size());
    end
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
